// File: rtl/bcd_display_scanner_if.sv
// ============================================================================
// Module      : bcd_display_scanner_if
// Description : BCD input and 7-segment display bundle for the display scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_display_scanner_if;
    logic [0:11] bcd_in;
    logic        load;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        err;

    modport master (
        output bcd_in,
        output load,
        output blank_lz,
        input  seg,
        input  an,
        input  err
    );

    modport slave (
        input  bcd_in,
        input  load,
        input  blank_lz,
        output seg,
        output an,
        output err
    );
endinterface

`default_nettype wire

// File: rtl/bcd_display_scanner.sv
// ============================================================================
// Module      : bcd_display_scanner
// Description : Multiplexed 3-digit 7-segment driver with leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_display_scanner #(
    parameter int N_DIGITS = 3,
    parameter int PRESCALE = 50000
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    bcd_display_scanner_if.slave  bus
);

    localparam int                 c_CNT_W   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(PRESCALE - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [6:0]         c_SEG_OFF = 7'h7F;
    localparam logic [2:0]         c_AN_OFF  = 3'b111;

    typedef enum logic [1:0] {
        DIG_HUND  = 2'd0,
        DIG_TENS  = 2'd1,
        DIG_UNITS = 2'd2
    } digit_t;

    logic [0:11]        r_shadow;
    logic [c_CNT_W-1:0] r_cnt;
    digit_t             r_idx;
    digit_t             w_idxNext;
    logic [6:0]         r_seg;
    logic [2:0]         r_an;
    logic               r_err;

    logic               w_wrap;
    logic [3:0]         w_hund;
    logic [3:0]         w_tens;
    logic [3:0]         w_units;
    logic [3:0]         w_digit;
    logic               w_blank;
    logic               w_gap;
    logic [2:0]         w_anOn;
    logic [6:0]         w_segNext;
    logic [2:0]         w_anNext;
    logic               w_errNext;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign w_hund  = r_shadow[0:3];
    assign w_tens  = r_shadow[4:7];
    assign w_units = r_shadow[8:11];
    assign w_wrap  = (r_cnt == c_CNT_MAX);

    // Shadow register and slot prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_cnt    <= '0;
        end else begin
            if (bus.load) begin
                r_shadow <= bus.bcd_in;
            end
            r_cnt <= w_wrap ? '0 : (r_cnt + c_CNT_ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= DIG_HUND;
        end else begin
            r_idx <= w_idxNext;
        end
    end

    always_comb begin
        w_idxNext = r_idx;
        w_digit   = w_hund;
        w_anOn    = c_AN_OFF;
        case (r_idx)
            DIG_HUND: begin
                w_digit = w_hund;
                w_anOn  = 3'b011;
                if (w_wrap) w_idxNext = DIG_TENS;
            end
            DIG_TENS: begin
                w_digit = w_tens;
                w_anOn  = 3'b101;
                if (w_wrap) w_idxNext = DIG_UNITS;
            end
            DIG_UNITS: begin
                w_digit = w_units;
                w_anOn  = 3'b110;
                if (w_wrap) w_idxNext = DIG_HUND;
            end
            default: begin
                w_idxNext = DIG_HUND;
            end
        endcase
    end

    // Only genuine zeros are blanked, so an invalid code always stays visible
    always_comb begin
        w_blank = 1'b0;
        if (bus.blank_lz) begin
            case (r_idx)
                DIG_HUND: w_blank = (w_hund == 4'd0);
                DIG_TENS: w_blank = (w_hund == 4'd0) && (w_tens == 4'd0);
                default:  w_blank = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_gap     = (r_cnt == '0) || w_blank;
        w_segNext = w_gap ? c_SEG_OFF : f_decode(w_digit);
        w_anNext  = w_gap ? c_AN_OFF  : w_anOn;
        w_errNext = (w_hund > 4'd9) || (w_tens > 4'd9) || (w_units > 4'd9);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= c_SEG_OFF;
            r_an  <= c_AN_OFF;
            r_err <= 1'b0;
        end else begin
            r_seg <= w_segNext;
            r_an  <= w_anNext;
            r_err <= w_errNext;
        end
    end

    assign bus.seg = r_seg;
    assign bus.an  = r_an;
    assign bus.err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
// ============================================================================
// Module      : tb_bcd_display_scanner
// Description : Self-checking bench for bcd_display_scanner (PRESCALE 4 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_display_scanner;

    logic clk = 1'b0;
    logic rst4_n;
    logic rst2_n;

    always #5 clk = ~clk;

    bcd_display_scanner_if if4 ();
    bcd_display_scanner_if if2 ();

    bcd_display_scanner #(.N_DIGITS(3), .PRESCALE(4)) dut4 (
        .clk   (clk),
        .rst_n (rst4_n),
        .bus   (if4)
    );

    bcd_display_scanner #(.N_DIGITS(3), .PRESCALE(2)) dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (if2)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] decTbl [16];

    typedef struct {
        logic [11:0] bcd;
        logic        blz;
        logic [6:0]  segH;
        logic [6:0]  segT;
        logic [6:0]  segU;
        logic        err;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: t edges since reset select slot = (t/P) mod 3 and phase = t mod P
    function automatic void model(input int p, input int t, input logic [11:0] sh,
                                  input logic blz, output logic [6:0] s,
                                  output logic [2:0] a, output logic e);
        int slot;
        int phase;
        int h;
        int tn;
        int u;
        int d;
        bit blank;
        slot  = (t / p) % 3;
        phase = t % p;
        h     = int'(sh[11:8]);
        tn    = int'(sh[7:4]);
        u     = int'(sh[3:0]);
        d     = (slot == 0) ? h : ((slot == 1) ? tn : u);
        blank = blz && (d <= 9) &&
                (((slot == 0) && (h == 0)) || ((slot == 1) && (h == 0) && (tn == 0)));
        if ((phase == 0) || blank) begin
            s = 7'h7F;
            a = 3'b111;
        end else begin
            s = decTbl[d];
            a = ~(3'b100 >> slot);
        end
        e = (h > 9) || (tn > 9) || (u > 9);
    endfunction

    task automatic check4(input string name, input logic [6:0] s, input logic [2:0] a,
                          input logic e);
        chk({name, " seg"}, {9'd0, if4.seg}, {9'd0, s});
        chk({name, " an"},  {13'd0, if4.an}, {13'd0, a});
        chk({name, " err"}, {15'd0, if4.err}, {15'd0, e});
    endtask

    task automatic reset4();
        @(negedge clk);
        rst4_n = 1'b0;
        if4.load = 1'b0;
        #1;
        check4("reset4", 7'h7F, 3'b111, 1'b0);
    endtask

    task automatic frame4(input int k, input vec_t v);
        logic [6:0] es;
        logic [2:0] ea;
        int slot;
        int phase;
        reset4();
        @(negedge clk);
        rst4_n       = 1'b1;
        if4.load     = 1'b1;
        if4.bcd_in   = v.bcd;
        if4.blank_lz = v.blz;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            if4.load = 1'b0;
            slot  = (e - 1) / 4;
            phase = (e - 1) % 4;
            es = (phase == 0) ? 7'h7F : ((slot == 0) ? v.segH : ((slot == 1) ? v.segT : v.segU));
            ea = (es == 7'h7F) ? 3'b111 : ((slot == 0) ? 3'b011 : ((slot == 1) ? 3'b101 : 3'b110));
            check4($sformatf("tbl%0d edge%0d", k, e), es, ea, (e == 1) ? 1'b0 : v.err);
        end
    endtask

    initial begin
        logic [11:0] sh;
        logic [11:0] v;
        logic        ld;
        logic        bz;
        logic [6:0]  s4;
        logic [6:0]  s2;
        logic [2:0]  a4;
        logic [2:0]  a2;
        logic        e4;
        logic        e2;
        int          t;

        decTbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                   7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                   7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

        tbl[0]  = '{12'h123, 1'b0, 7'b1111001, 7'b0100100, 7'b0110000, 1'b0};
        tbl[1]  = '{12'h005, 1'b1, 7'h7F,      7'h7F,      7'b0010010, 1'b0};
        tbl[2]  = '{12'h000, 1'b1, 7'h7F,      7'h7F,      7'b1000000, 1'b0};
        tbl[3]  = '{12'h0A0, 1'b0, 7'b1000000, 7'b0111111, 7'b1000000, 1'b1};
        tbl[4]  = '{12'h0A0, 1'b1, 7'h7F,      7'b0111111, 7'b1000000, 1'b1};
        tbl[5]  = '{12'h100, 1'b0, 7'b1111001, 7'b1000000, 7'b1000000, 1'b0};
        tbl[6]  = '{12'h050, 1'b1, 7'h7F,      7'b0010010, 7'b1000000, 1'b0};
        tbl[7]  = '{12'hF09, 1'b1, 7'b0111111, 7'b1000000, 7'b0010000, 1'b1};
        tbl[8]  = '{12'h678, 1'b1, 7'b0000010, 7'b1111000, 7'b0000000, 1'b0};
        tbl[9]  = '{12'h049, 1'b1, 7'h7F,      7'b0011001, 7'b0010000, 1'b0};
        tbl[10] = '{12'h300, 1'b1, 7'b0110000, 7'b1000000, 7'b1000000, 1'b0};

        rst4_n = 1'b0;
        rst2_n = 1'b0;
        if4.bcd_in = '0; if4.load = 1'b0; if4.blank_lz = 1'b0;
        if2.bcd_in = '0; if2.load = 1'b0; if2.blank_lz = 1'b0;

        for (int k = 0; k < 11; k++) begin
            frame4(k, tbl[k]);
        end

        // Asynchronous reset in the middle of a slot
        reset4();
        @(negedge clk);
        rst4_n = 1'b1; if4.load = 1'b1; if4.bcd_in = 12'hA23; if4.blank_lz = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            #1;
            if4.load = 1'b0;
        end
        check4("pre-reset edge5", 7'h7F, 3'b111, 1'b1);
        #2;
        rst4_n = 1'b0;
        #1;
        check4("async reset", 7'h7F, 3'b111, 1'b0);
        @(negedge clk);
        rst4_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            check4($sformatf("post-reset edge%0d", e), (e == 1) ? 7'h7F : 7'b1000000,
                   (e == 1) ? 3'b111 : 3'b011, 1'b0);
        end

        // Load in the middle of the units ON phase
        reset4();
        @(negedge clk);
        rst4_n = 1'b1; if4.load = 1'b1; if4.bcd_in = 12'h123; if4.blank_lz = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk);
            #1;
            if4.load = 1'b0;
        end
        if4.load = 1'b1; if4.bcd_in = 12'h127;
        @(posedge clk); #1; if4.load = 1'b0;
        check4("midload edge10", 7'b0110000, 3'b110, 1'b0);
        @(posedge clk); #1;
        check4("midload edge11", 7'b1111000, 3'b110, 1'b0);
        @(posedge clk); #1;
        check4("midload edge12", 7'b1111000, 3'b110, 1'b0);
        @(posedge clk); #1;
        check4("midload edge13", 7'h7F, 3'b111, 1'b0);
        @(posedge clk); #1;
        check4("midload edge14", 7'b1111001, 3'b011, 1'b0);

        // PRESCALE=2 anode sequence over more than one frame
        @(negedge clk);
        rst2_n = 1'b0;
        @(negedge clk);
        rst2_n = 1'b1; if2.load = 1'b1; if2.bcd_in = 12'h123; if2.blank_lz = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            logic [2:0] seqAn [6];
            seqAn = '{3'b111, 3'b011, 3'b111, 3'b101, 3'b111, 3'b110};
            @(posedge clk);
            #1;
            if2.load = 1'b0;
            chk($sformatf("p2 an edge%0d", e), {13'd0, if2.an}, {13'd0, seqAn[(e - 1) % 6]});
        end

        // Randomized run of both instances against the reference model
        @(negedge clk);
        rst4_n = 1'b0;
        rst2_n = 1'b0;
        sh = '0;
        t  = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            rst4_n = 1'b1;
            rst2_n = 1'b1;
            ld = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end else begin
                v = 12'($urandom);
            end
            bz = 1'($urandom_range(0, 1));
            if4.load = ld; if4.bcd_in = v; if4.blank_lz = bz;
            if2.load = ld; if2.bcd_in = v; if2.blank_lz = bz;
            model(4, t, sh, bz, s4, a4, e4);
            model(2, t, sh, bz, s2, a2, e2);
            @(posedge clk);
            #1;
            check4($sformatf("rnd4 n%0d", n), s4, a4, e4);
            chk($sformatf("rnd2 n%0d seg", n), {9'd0, if2.seg}, {9'd0, s2});
            chk($sformatf("rnd2 n%0d an", n), {13'd0, if2.an}, {13'd0, a2});
            chk($sformatf("rnd2 n%0d err", n), {15'd0, if2.err}, {15'd0, e2});
            if (ld) sh = v;
            t++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
